mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Iterative multiply/divide unit with its HI/LO register pair, sitting in EX directly downstream of the ID-stage general-purpose register file. It consumes the two register read operands (after forwarding) for MULT/MULTU/DIV/DIVU. It holds the 64-bit result in HI/LO for MFHI/MFLO. While an operation is in flight it raises `busy` so the hazard unit stalls any dependent HI/LO access.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `start`  in  1  launch operation `op` on `a`,`b`; honoured only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand / dividend).
- `b`  in  32  rt operand (multiplier / divisor).
- `mthi`  in  1  write `a` into HI; honoured only when `busy`=0.
- `mtlo`  in  1  write `a` into LO; honoured only when `busy`=0.
- `flush`  in  1  abort in-flight operation (exception/branch squash).
- `busy`  out  1  operation in progress; registered.
- `hi`  out  32  HI register; registered.
- `lo`  out  32  LO register; registered.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1:
  - Latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned).
  - Latch result sign: a[31]^b[31] for MULT and DIV. Latch remainder sign: a[31] for DIV.
  - Clear 5-bit counter; go to CALC.
- CALC, one iteration per cycle, 32 iterations:
  - Multiply: shift-add radix-2 into a 64-bit accumulator.
  - Divide: restoring shift-subtract, with the 33-bit partial remainder in the accumulator's upper half and the quotient in the lower half.
  - When the counter reaches 31, go to FIX.
- FIX:
  - Apply sign correction (two's-complement negate of the 64-bit product; or of the quotient and remainder independently).
  - Write HI/LO, go to IDLE.
- Multiply results: HI = product[63:32], LO = product[31:0].
- Divide results: LO = quotient, HI = remainder. Remainder takes the sign of the dividend.
- Divide by zero, either signedness: LO = 32'hFFFFFFFF, HI = `a` as presented. Same latency as a normal divide.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0. No trap.
- `mthi`/`mtlo` in IDLE with `start`=0: register written at the next edge. Both may assert together; both HI and LO then take `a`.
- Simultaneous events:
  - `start` together with `mthi`/`mtlo` in IDLE: `start` wins, the write is discarded.
  - `start`, `mthi` or `mtlo` while `busy`=1: ignored, no side effect.
- `flush`, in any state: go to IDLE at the next edge, `busy`=0, HI/LO keep their pre-operation values. `flush` has priority over `start` in the same cycle.
- `reset`=0: state IDLE, counter 0, `busy`=0, `hi`=0, `lo`=0. Takes effect at the next edge regardless of state; mid-operation results are lost.

## Timing
- `start` sampled at edge E0. `busy`=1 from just after E0 until just after E33.
- CALC occupies edges E1..E32; FIX executes at E33.
- `hi`/`lo` show the new result and `busy`=0 after E33. Total latency 33 cycles.
- A new `start` is accepted in the cycle after E33 (back-to-back operations).
- `mthi`/`mtlo` latency: 1 cycle.
- `hi`/`lo` never change mid-operation; they only change on FIX, MTHI/MTLO or reset.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU compute the 64-bit product in one step at E0, going IDLE→FIX.
  - FIX at E1 writes HI/LO; `busy`=1 for exactly one cycle.
  - Divide behaviour is unchanged.
- Undefined: multiply uses the 33-cycle iterative path described above.

## Test plan
- MULT a=32'hFFFFFFFF, b=2 -> after 33 cycles HI=32'hFFFFFFFF, LO=32'hFFFFFFFE. `busy` high for exactly 33 cycles (1 with `MDU_FAST_MUL_EN`).
- MULTU a=32'hFFFFFFFF, b=2 -> HI=1, LO=32'hFFFFFFFE. DIVU a=100, b=7 -> LO=14, HI=2.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIV 32'h80000000/32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- DIVU a=5, b=0 -> LO=32'hFFFFFFFF, HI=5 after 33 cycles.
- Preload HI=32'h11, LO=32'h22 via `mthi`/`mtlo`, then:
  - Start DIV; assert `flush` at cycle 10 -> `busy`=0 next cycle, HI=32'h11, LO=32'h22.
  - `mthi` while busy is ignored.
  - Repeat with `reset`=0 at cycle 10 -> HI=0, LO=0, `busy`=0.
- Back-to-back: MULTU 3*4 then DIVU 9/2 started the cycle `busy` falls -> first result HI=0, LO=12; second result HI=1, LO=4. A `start` coincident with `mtlo` writes nothing to LO.

Source files
------------

// File: rtl/mdu_hilo.sv
// Iterative 32-bit multiply/divide unit with its HI/LO register pair.
// Optional macro MDU_FAST_MUL_EN: single-step MULT/MULTU (IDLE->FIX), divide stays iterative.
module mdu_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;
  logic [64:0] acc_q, acc_d;
  logic        sign_q, sign_d;
  logic        rsign_q, rsign_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [64:0] div_shl;
  logic [33:0] div_diff;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    // op[0]=0 selects the signed variants
    a_mag    = (!op[0] && a[31]) ? (32'd0 - a) : a;
    b_mag    = (!op[0] && b[31]) ? (32'd0 - b) : b;
    mul_sum  = acc_q[64:32] + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shl  = {acc_q[63:0], 1'b0};
    div_diff = {1'b0, div_shl[64:32]} - {2'b00, opnd_q};
    prod     = sign_q ? (64'd0 - acc_q[63:0]) : acc_q[63:0];
    quo      = dz_q ? 32'hFFFFFFFF : (sign_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
    rem      = rsign_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (start) begin
          op_d    = op;
          sign_d  = !op[0] && (a[31] ^ b[31]);
          rsign_d = (op == 2'b10) && a[31];
          dz_d    = op[1] && (b == 32'd0);
          cnt_d   = 5'd0;
          if (op[1]) begin
            acc_d   = {33'd0, a_mag};
            opnd_d  = b_mag;
            state_d = CALC;
          end else begin
`ifdef MDU_FAST_MUL_EN
            acc_d   = {1'b0, {32'd0, a_mag} * {32'd0, b_mag}};
            state_d = FIX;
`else
            acc_d   = {33'd0, b_mag};
            opnd_d  = a_mag;
            state_d = CALC;
`endif
          end
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (op_q[1]) begin
            // restoring step: keep the subtraction only when it does not borrow
            if (!div_diff[33]) acc_d = {div_diff[32:0], div_shl[31:1], 1'b1};
            else               acc_d = div_shl;
          end else begin
            acc_d = {1'b0, mul_sum, acc_q[31:1]};
          end
          if (cnt_q == 5'd31) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          if (op_q[1]) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      opnd_q  <= 32'd0;
      acc_q   <= 65'd0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      rsign_q <= rsign_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus random ops against an arithmetic model.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          errors = 0;

  mdu_hilo dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: model = sx * sy;
      2'b01: model = ux * uy;
      2'b10: begin
        if (y == 32'd0) model = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          model = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) model = {x, 32'hFFFFFFFF};
        else model = {(x % y), (x / y)};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
    exp_lat = o[1] ? 33 : 1;
`else
    exp_lat = 33;
`endif
  endfunction

  // Called at a negedge; returns at the negedge where busy is first seen low.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic with_mtlo);
    logic [63:0] exp;
    logic [31:0] pre_hi, pre_lo;
    int          n;
    bit          moved;
    exp    = model(o, x, y);
    pre_hi = hi;
    pre_lo = lo;
    moved  = 1'b0;
    n      = 0;
    start  = 1'b1; op = o; a = x; b = y; mtlo = with_mtlo;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    if (with_mtlo) chk({tag, "_mtlo_discard"}, lo, pre_lo);
    while (busy && n < 200) begin
      n++;
      if (hi !== pre_hi || lo !== pre_lo) moved = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_lat(o)));
    chk({tag, "_hilo_stable"}, {31'd0, moved}, 32'd0);
    chk({tag, "_hi"}, hi, exp[63:32]);
    chk({tag, "_lo"}, lo, exp[31:0]);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("mult_m1x2", 2'b00, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_op("multu_m1x2", 2'b01, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 1'b0);
    run_op("div_by0", 2'b10, 32'hFFFFFF00, 32'd0, 1'b0);

    // Both move-to writes together.
    mthi = 1'b1; mtlo = 1'b1; a = 32'hA5A5_0F0F;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", hi, 32'hA5A5_0F0F);
    chk("mthilo_lo", lo, 32'hA5A5_0F0F);

    // Preload, then flush mid-divide with an ignored mthi while busy.
    mthi = 1'b1; a = 32'h11;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; a = 32'h22;
    @(negedge clk);
    mtlo = 1'b0;
    chk("preload_hi", hi, 32'h11);
    chk("preload_lo", lo, 32'h22);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0; mthi = 1'b1; a = 32'hDEAD;
    @(negedge clk);
    mthi = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'h11);
    chk("flush_lo", lo, 32'h22);

    // Same again, aborted by reset.
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);

    // Back-to-back, second start coincident with mtlo.
    run_op("b2b_multu", 2'b01, 32'd3, 32'd4, 1'b0);
    run_op("b2b_divu", 2'b11, 32'd9, 32'd2, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       ra = 32'h80000000;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
